enduro_game_ctrl: RTL and testbench
===================================

# enduro_game_ctrl

Parametrised successor to the single-player `game_state` controller. It drives the game phase, speed ramp, score and collision handling for NUM_CARS opponent cars. It sits between `get_cars_pos` (positions in) and `draw_dynamic_cars` / the position updater (phase and speed out), and advances once per `frame_tick` from `clock_divider`.

## Interface
- NUM_CARS, 2: opponent car count (1..8)
- POS_W, 10: width of every x/y coordinate
- CAR_W, 23: car bounding-box width, pixels
- CAR_H, 36: car bounding-box height, pixels
- COUNT_FRAMES, 60: countdown length in frames
- SPEEDUP_FRAMES, 300: RUN frames per speed step
- MAX_SPEED, 7: speed ceiling (≤7)
- SCORE_W, 16: score width
- LIVES, 3: initial lives (used only with ENDURO_LIVES_EN)
- CRASH_FRAMES, 90: crash recovery length in frames
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame
- start  in  1  level; starts the game from IDLE
- restart  in  1  level; returns to IDLE from any state
- car_user_x / car_user_y  in  POS_W each  player car top-left corner
- cars_x / cars_y  in  NUM_CARS*POS_W each  opponent top-left corners; car i occupies bits [i*POS_W +: POS_W]
- BEGINNING  out  1  high in IDLE
- SHOW_CARS  out  1  high in RUN and CRASH
- END  out  1  high in OVER
- SPEED  out  3  current speed level
- score  out  SCORE_W  accumulated score
- lives  out  2  remaining lives
- crash  out  1  one-cycle pulse when a collision is accepted

## Operation
- States: IDLE, COUNTDOWN, RUN, CRASH, OVER.
- IDLE -> COUNTDOWN on any cycle with start=1. Entering COUNTDOWN clears score, sets SPEED=1 and loads lives=LIVES.
- COUNTDOWN -> RUN after COUNT_FRAMES frame_ticks.
- RUN, on each frame_tick:
  - score += SPEED, saturating at 2^SCORE_W-1.
  - The speed-up counter advances. When it reaches SPEEDUP_FRAMES, SPEED increments (saturating at MAX_SPEED) and the counter clears.
- Collision with car i when all four hold: ux < cx_i+CAR_W, cx_i < ux+CAR_W, uy < cy_i+CAR_H, cy_i < uy+CAR_H. Sums are computed at POS_W+1 bits, so no wrap.
- Collisions are evaluated only on a frame_tick cycle in RUN. Any number of simultaneous overlaps counts as one collision: one crash pulse, one life.
- On a collision: crash=1 and SPEED drops to 1. Next state follows Configuration.
- CRASH lasts CRASH_FRAMES frame_ticks, then returns to RUN with the speed counter cleared. Collisions are ignored during CRASH.
- OVER holds all outputs until restart.
- restart has priority over start and over all frame events. The next state is IDLE, with score and SPEED held.

## Timing
- All outputs are registered. Values after rst: BEGINNING=1, SHOW_CARS=0, END=0, SPEED=0, score=0, lives=0, crash=0, state=IDLE.
- start/restart take effect one cycle after sampling. Frame-driven transitions update on the edge where frame_tick=1.
- crash, score and SPEED change one cycle after the frame_tick edge is sampled.
- If frame_tick coincides with start in IDLE, the tick is not counted toward the countdown.
- rst mid-game aborts immediately to the reset values; no partial frame effects.
- A countdown or recovery of 0 frames is illegal; the minimum is 1.

## Configuration
- `ENDURO_LIVES_EN` defined:
  - A collision decrements lives.
  - If lives was 1, next state is OVER (lives=0).
  - Otherwise next state is CRASH.
- Undefined:
  - lives stays 0 and the CRASH state is unreachable.
  - The first collision goes straight to OVER.

## Structure
- Package `enduro_pkg` holds:
  - the state enum;
  - SPEED_W=3;
  - the default screen and car geometry constants shared with `draw_dynamic_cars`.
- Sub-module `car_overlap`: a combinational AABB test for one opponent. It is instantiated NUM_CARS times in a generate loop, and its outputs are OR-reduced.

## Test plan
- **Reset and idle:** rst 3 cycles, then start=1 for 1 cycle.
  - COUNTDOWN entered; SPEED=1, score=0, BEGINNING=0.
  - RUN is reached after exactly 60 ticks.
- **Scoring and speed ramp:** RUN with no overlap, 900 ticks.
  - SPEED steps 1->2->3->4 at ticks 300, 600 and 900.
  - score = 300·1 + 300·2 + 300·3 = 1800.
- **Double collision:** player (200,444); car0 at (210,430), car1 at (190,440); one tick.
  - Exactly one crash pulse.
  - With ENDURO_LIVES_EN: lives 3->2, state CRASH.
- **Edge abutment:** player x=200, car x=223 (exactly CAR_W apart), y overlapping.
  - No collision.
  - At car x=222, a collision occurs.
- **Game over (ENDURO_LIVES_EN):** 3 collisions separated by 90-tick recoveries.
  - END=1, lives=0.
  - score frozen across 100 further ticks.
  - restart -> BEGINNING=1 next cycle.
- **Priority and reset:** start=1 and restart=1 together in IDLE -> stays IDLE. rst asserted in RUN -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/enduro_pkg.sv
// Shared types and geometry for the Enduro game controller and car drawing.
// Build option: ENDURO_LIVES_EN enables the multi-life crash/recovery path.
package enduro_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_RUN,
    S_CRASH,
    S_OVER
  } state_e;

  localparam int SPEED_W   = 3;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int POS_W_DEF = 10;
  localparam int CAR_W_DEF = 23;
  localparam int CAR_H_DEF = 36;

  function automatic logic [SPEED_W-1:0] speed_up(
    input logic [SPEED_W-1:0] s,
    input logic [SPEED_W-1:0] lim
  );
    return (s >= lim) ? lim : s + 1'b1;
  endfunction

endpackage

// File: rtl/car_overlap.sv
// Combinational bounding-box overlap test between the player and one opponent.
// Sums are one bit wider than the coordinates so edges near the screen limit never wrap.
module car_overlap
  import enduro_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int CAR_W = CAR_W_DEF,
  parameter int CAR_H = CAR_H_DEF
) (
  input  logic [POS_W-1:0] ux_i,
  input  logic [POS_W-1:0] uy_i,
  input  logic [POS_W-1:0] cx_i,
  input  logic [POS_W-1:0] cy_i,
  output logic             hit_o
);

  localparam logic [POS_W:0] W = (POS_W+1)'(CAR_W);
  localparam logic [POS_W:0] H = (POS_W+1)'(CAR_H);

  logic [POS_W:0] ux;
  logic [POS_W:0] uy;
  logic [POS_W:0] cx;
  logic [POS_W:0] cy;

  assign ux = {1'b0, ux_i};
  assign uy = {1'b0, uy_i};
  assign cx = {1'b0, cx_i};
  assign cy = {1'b0, cy_i};

  assign hit_o = (ux < cx + W) && (cx < ux + W) &&
                 (uy < cy + H) && (cy < uy + H);

endmodule

// File: rtl/enduro_game_ctrl.sv
// Enduro game phase, speed ramp, score and collision controller for NUM_CARS opponents.
// Build option: ENDURO_LIVES_EN (lives and crash recovery; otherwise first hit ends the game).
module enduro_game_ctrl
  import enduro_pkg::*;
#(
  parameter int NUM_CARS       = 2,
  parameter int POS_W          = 10,
  parameter int CAR_W          = 23,
  parameter int CAR_H          = 36,
  parameter int COUNT_FRAMES   = 60,
  parameter int SPEEDUP_FRAMES = 300,
  parameter int MAX_SPEED      = 7,
  parameter int SCORE_W        = 16,
  parameter int LIVES          = 3,
  parameter int CRASH_FRAMES   = 90
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic                      start,
  input  logic                      restart,
  input  logic [POS_W-1:0]          car_user_x,
  input  logic [POS_W-1:0]          car_user_y,
  input  logic [NUM_CARS*POS_W-1:0] cars_x,
  input  logic [NUM_CARS*POS_W-1:0] cars_y,
  output logic                      BEGINNING,
  output logic                      SHOW_CARS,
  output logic                      END,
  output logic [SPEED_W-1:0]        SPEED,
  output logic [SCORE_W-1:0]        score,
  output logic [1:0]                lives,
  output logic                      crash
);

`ifdef ENDURO_LIVES_EN
  localparam logic LIV_EN = 1'b1;
`else
  localparam logic LIV_EN = 1'b0;
`endif

  localparam int CNT_MAX = (COUNT_FRAMES > CRASH_FRAMES) ?
                           COUNT_FRAMES : CRASH_FRAMES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int SU_W  = $clog2(SPEEDUP_FRAMES + 1);
  localparam int SW1   = SCORE_W + 1;

  localparam logic [CNT_W-1:0]   CD_LAST = CNT_W'(COUNT_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CR_LAST = CNT_W'(CRASH_FRAMES - 1);
  localparam logic [SU_W-1:0]    SU_LAST = SU_W'(SPEEDUP_FRAMES - 1);
  localparam logic [SPEED_W-1:0] MAX_SPD = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] SPD_1   = SPEED_W'(1);
  localparam logic [1:0]         LIV_INI = 2'(LIVES) & {2{LIV_EN}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SU_W-1:0]    su_q, su_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic               crash_q, crash_d;
  logic               beg_q, show_q, end_q;

  logic [NUM_CARS-1:0] hit;
  logic                any_hit;
  logic [SW1-1:0]      score_sum;

  for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
    car_overlap #(
      .POS_W (POS_W),
      .CAR_W (CAR_W),
      .CAR_H (CAR_H)
    ) u_ov (
      .ux_i  (car_user_x),
      .uy_i  (car_user_y),
      .cx_i  (cars_x[i*POS_W +: POS_W]),
      .cy_i  (cars_y[i*POS_W +: POS_W]),
      .hit_o (hit[i])
    );
  end

  assign any_hit   = |hit;
  assign score_sum = SW1'(score_q) + SW1'(speed_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    su_d    = su_q;
    speed_d = speed_q;
    score_d = score_q;
    lives_d = lives_q;
    crash_d = 1'b0;
    if (restart) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      su_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_COUNTDOWN;
            cnt_d   = '0;
            su_d    = '0;
            score_d = '0;
            speed_d = SPD_1;
            lives_d = LIV_INI;
          end
        end
        S_COUNTDOWN: begin
          if (frame_tick) begin
            if (cnt_q == CD_LAST) begin
              state_d = S_RUN;
              cnt_d   = '0;
              su_d    = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (frame_tick) begin
            score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            if (su_q == SU_LAST) begin
              su_d    = '0;
              speed_d = speed_up(speed_q, MAX_SPD);
            end else begin
              su_d = su_q + 1'b1;
            end
            // A hit overrides the ramp; any number of overlaps is one event
            if (any_hit) begin
              crash_d = 1'b1;
              speed_d = SPD_1;
              cnt_d   = '0;
`ifdef ENDURO_LIVES_EN
              lives_d = lives_q - 2'd1;
              state_d = (lives_q == 2'd1) ? S_OVER : S_CRASH;
`else
              state_d = S_OVER;
`endif
            end
          end
        end
        S_CRASH: begin
          if (frame_tick) begin
            if (cnt_q == CR_LAST) begin
              state_d = S_RUN;
              cnt_d   = '0;
              su_d    = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_OVER: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      su_q    <= '0;
      speed_q <= '0;
      score_q <= '0;
      lives_q <= '0;
      crash_q <= 1'b0;
      beg_q   <= 1'b1;
      show_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      su_q    <= su_d;
      speed_q <= speed_d;
      score_q <= score_d;
      lives_q <= lives_d;
      crash_q <= crash_d;
      beg_q   <= (state_d == S_IDLE);
      show_q  <= (state_d == S_RUN) || (state_d == S_CRASH);
      end_q   <= (state_d == S_OVER);
    end
  end

  assign BEGINNING = beg_q;
  assign SHOW_CARS = show_q;
  assign END       = end_q;
  assign SPEED     = speed_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign crash     = crash_q;

endmodule

// File: tb/tb_enduro_game_ctrl.sv
// Directed testbench for enduro_game_ctrl, default and ENDURO_LIVES_EN builds.
module tb_enduro_game_ctrl;

`ifdef ENDURO_LIVES_EN
  localparam logic [1:0] EXP_LIVES = 2'd3;
`else
  localparam logic [1:0] EXP_LIVES = 2'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        restart = 1'b0;
  logic [9:0]  car_user_x = 10'd200;
  logic [9:0]  car_user_y = 10'd444;
  logic [19:0] cars_x = '0;
  logic [19:0] cars_y = '0;
  logic        BEGINNING;
  logic        SHOW_CARS;
  logic        END;
  logic [2:0]  SPEED;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        crash;

  int pass_cnt = 0;
  int total = 0;

  always #20 clk = ~clk;

  enduro_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .restart    (restart),
    .car_user_x (car_user_x),
    .car_user_y (car_user_y),
    .cars_x     (cars_x),
    .cars_y     (cars_y),
    .BEGINNING  (BEGINNING),
    .SHOW_CARS  (SHOW_CARS),
    .END        (END),
    .SPEED      (SPEED),
    .score      (score),
    .lives      (lives),
    .crash      (crash)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      step();
    end
  endtask

  task automatic set_cars(input int x0, input int y0,
                          input int x1, input int y1);
    cars_x = {10'(x1), 10'(x0)};
    cars_y = {10'(y1), 10'(y0)};
  endtask

  task automatic cars_away();
    set_cars(0, 0, 500, 0);
  endtask

  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
    ticks(60);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if ({BEGINNING, SHOW_CARS, END, crash} !== 4'b1000)
      $display("FAIL reset_flags got %b expected 1000",
               {BEGINNING, SHOW_CARS, END, crash});
    else pass_cnt++;
    total++;
    if (SPEED !== 3'd0) $display("FAIL reset_speed got %0d expected 0", SPEED);
    else pass_cnt++;
    total++;
    if (score !== 16'd0) $display("FAIL reset_score got %0d expected 0", score);
    else pass_cnt++;
    total++;
    if (lives !== 2'd0) $display("FAIL reset_lives got %0d expected 0", lives);
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_countdown();
    cars_away();
    start = 1'b1;
    frame_tick = 1'b1;
    step();
    start = 1'b0;
    frame_tick = 1'b0;
    total++;
    if (BEGINNING !== 1'b0) $display("FAIL cd_beginning got %b expected 0", BEGINNING);
    else pass_cnt++;
    total++;
    if (SPEED !== 3'd1) $display("FAIL cd_speed got %0d expected 1", SPEED);
    else pass_cnt++;
    total++;
    if (score !== 16'd0) $display("FAIL cd_score got %0d expected 0", score);
    else pass_cnt++;
    total++;
    if (lives !== EXP_LIVES) $display("FAIL cd_lives got %0d expected %0d", lives, EXP_LIVES);
    else pass_cnt++;
    step();
    ticks(59);
    total++;
    if (SHOW_CARS !== 1'b0) $display("FAIL cd_59_ticks got %b expected 0", SHOW_CARS);
    else pass_cnt++;
    tick();
    total++;
    if (SHOW_CARS !== 1'b1) $display("FAIL cd_60_ticks got %b expected 1", SHOW_CARS);
    else pass_cnt++;
    step();
  endtask

  task automatic test_speed_ramp();
    logic [2:0]  exp_spd [3] = '{3'd2, 3'd3, 3'd4};
    logic [15:0] exp_sc [3] = '{16'd300, 16'd900, 16'd1800};
    ticks(299);
    total++;
    if (SPEED !== 3'd1 || score !== 16'd299)
      $display("FAIL ramp_299 got speed %0d score %0d expected 1 299", SPEED, score);
    else pass_cnt++;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) ticks(299);
      tick();
      total++;
      if (SPEED !== exp_spd[s] || score !== exp_sc[s])
        $display("FAIL ramp_step%0d got speed %0d score %0d expected %0d %0d",
                 s, SPEED, score, exp_spd[s], exp_sc[s]);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_double_collision();
    set_cars(210, 430, 190, 440);
    tick();
    total++;
    if (crash !== 1'b1 || SPEED !== 3'd1 || score !== 16'd1804)
      $display("FAIL dbl_hit got crash %b speed %0d score %0d expected 1 1 1804",
               crash, SPEED, score);
    else pass_cnt++;
`ifdef ENDURO_LIVES_EN
    total++;
    if (lives !== 2'd2 || END !== 1'b0 || SHOW_CARS !== 1'b1)
      $display("FAIL dbl_state got lives %0d end %b show %b expected 2 0 1",
               lives, END, SHOW_CARS);
    else pass_cnt++;
`else
    total++;
    if (lives !== 2'd0 || END !== 1'b1)
      $display("FAIL dbl_state got lives %0d end %b expected 0 1", lives, END);
    else pass_cnt++;
`endif
    step();
    total++;
    if (crash !== 1'b0) $display("FAIL dbl_one_pulse got %b expected 0", crash);
    else pass_cnt++;
  endtask

  task automatic test_crash_recovery(input logic [15:0] sc);
    int pulses = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (crash === 1'b1) pulses++;
      step();
    end
    total++;
    if (pulses != 0 || score !== sc)
      $display("FAIL recov_ignore got pulses %0d score %0d expected 0 %0d",
               pulses, score, sc);
    else pass_cnt++;
  endtask

  task automatic test_edge_abutment(input logic [15:0] base);
    set_cars(223, 444, 500, 0);
    tick();
    total++;
    if (crash !== 1'b0 || score !== base + 16'd1)
      $display("FAIL abut_223 got crash %b score %0d expected 0 %0d",
               crash, score, base + 16'd1);
    else pass_cnt++;
    step();
    set_cars(222, 444, 500, 0);
    tick();
    total++;
    if (crash !== 1'b1 || score !== base + 16'd2)
      $display("FAIL abut_222 got crash %b score %0d expected 1 %0d",
               crash, score, base + 16'd2);
    else pass_cnt++;
`ifdef ENDURO_LIVES_EN
    total++;
    if (lives !== 2'd1 || END !== 1'b0)
      $display("FAIL abut_lives got lives %0d end %b expected 1 0", lives, END);
    else pass_cnt++;
`else
    total++;
    if (END !== 1'b1) $display("FAIL abut_over got %b expected 1", END);
    else pass_cnt++;
`endif
    step();
  endtask

  task automatic test_over_hold(input logic [15:0] sc);
    ticks(100);
    total++;
    if (END !== 1'b1 || score !== sc)
      $display("FAIL over_hold got end %b score %0d expected 1 %0d", END, score, sc);
    else pass_cnt++;
    restart = 1'b1;
    step();
    restart = 1'b0;
    total++;
    if (BEGINNING !== 1'b1 || score !== sc || SPEED !== 3'd1)
      $display("FAIL restart got beg %b score %0d speed %0d expected 1 %0d 1",
               BEGINNING, score, SPEED, sc);
    else pass_cnt++;
  endtask

  task automatic test_priority_reset();
    start = 1'b1;
    restart = 1'b1;
    step();
    start = 1'b0;
    restart = 1'b0;
    total++;
    if (BEGINNING !== 1'b1) $display("FAIL prio_idle got %b expected 1", BEGINNING);
    else pass_cnt++;
    step();
    total++;
    if (BEGINNING !== 1'b1 || SHOW_CARS !== 1'b0)
      $display("FAIL prio_hold got beg %b show %b expected 1 0", BEGINNING, SHOW_CARS);
    else pass_cnt++;
    cars_away();
    start_game();
    ticks(3);
    total++;
    if (SHOW_CARS !== 1'b1 || score !== 16'd3)
      $display("FAIL prio_run got show %b score %0d expected 1 3", SHOW_CARS, score);
    else pass_cnt++;
    rst = 1'b1;
    frame_tick = 1'b1;
    step();
    rst = 1'b0;
    frame_tick = 1'b0;
    total++;
    if ({BEGINNING, SHOW_CARS, END, crash} !== 4'b1000 ||
        SPEED !== 3'd0 || score !== 16'd0 || lives !== 2'd0)
      $display("FAIL rst_mid got flags %b speed %0d score %0d lives %0d expected 1000 0 0 0",
               {BEGINNING, SHOW_CARS, END, crash}, SPEED, score, lives);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_speed_ramp();
    test_double_collision();
`ifdef ENDURO_LIVES_EN
    test_crash_recovery(16'd1804);
    cars_away();
    tick();
    total++;
    if (score !== 16'd1805) $display("FAIL recov_run got %0d expected 1805", score);
    else pass_cnt++;
    step();
    test_edge_abutment(16'd1805);
    test_crash_recovery(16'd1807);
    tick();
    total++;
    if (crash !== 1'b1 || lives !== 2'd0 || END !== 1'b1 || score !== 16'd1808)
      $display("FAIL game_over got crash %b lives %0d end %b score %0d expected 1 0 1 1808",
               crash, lives, END, score);
    else pass_cnt++;
    step();
    test_over_hold(16'd1808);
`else
    test_over_hold(16'd1804);
    cars_away();
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (score !== 16'd0 || SPEED !== 3'd1)
      $display("FAIL new_game got score %0d speed %0d expected 0 1", score, SPEED);
    else pass_cnt++;
    ticks(60);
    test_edge_abutment(16'd0);
    restart = 1'b1;
    step();
    restart = 1'b0;
`endif
    test_priority_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
